hazard_scoreboard: RTL
======================

# hazard_scoreboard

Parametrised hazard controller for the 5-stage pipeline (IF, ID, EX, MEM, WB). It tracks in-flight register writes in a registered shadow pipeline, and from that derives load-use and RAW stalls, with or without forwarding. It also generates control-transfer flushes for a configurable resolve stage and freezes the whole pipeline on data-memory wait. It keeps saturating stall and flush counters for performance bring-up.

## Interface
- `RW`, 5: register-select width; register 0 is hardwired zero.
- `FWD`, 1: 1 = forwarding datapath present; 0 = no forwarding.
- `NSH`, 3: shadow depth, i.e. stages tracked after ID (EX=1, MEM=2, WB=3).
- `LOAD_USE_DIST`, 1: with `FWD`=1, a load in shadow stage k ≤ this value blocks a dependent ID instruction.
- `RESOLVE_STAGE`, 2: stage resolving branches/jumps; 1 = EX, 2 = MEM.
- `CNT_W`, 32: perf counter width.

Ports:
- `CLK` in 1: clock.
- `RST` in 1: synchronous, active-high reset.
- `id_valid` in 1: the ID slot holds a real instruction.
- `id_rs`, `id_rt` in RW: ID source registers.
- `id_rs_used`, `id_rt_used` in 1: the source is actually read.
- `id_wen` in 1: the ID instruction writes a register.
- `id_wsel` in RW: destination register.
- `id_is_load` in 1: the ID instruction is a load.
- `mem_wait` in 1: data memory not ready; freezes the pipeline.
- `resolve_valid`, `resolve_taken` in 1: a control transfer is at `RESOLVE_STAGE`; taken = redirect.
- `pc_en`, `ifid_en`, `idex_en`, `exmem_en`, `memwb_en` out 1: latch enables.
- `ifid_flush`, `idex_flush`, `exmem_flush` out 1: latch clears (bubble insert).
- `data_stall` out 1: RAW stall is in effect this cycle.
- `stall_cnt`, `flush_cnt` out CNT_W: saturating perf counters.

## Operation
- **Shadow state.** Registers `sh[1..NSH]`, each holding {valid, wsel, is_load}. They mirror the write intent of the instructions in EX..WB.
- **Match.** A source s (used, s≠0) matches `sh[k]` when `sh[k].valid` and `sh[k].wsel`==s.
- **Hazard with `FWD`=0.** Any match at k ∈ 1..NSH.
- **Hazard with `FWD`=1.** Only a match where `sh[k].is_load` and k ≤ `LOAD_USE_DIST`.
- `data_stall` = `id_valid` & hazard & !`mem_wait` & !taken, where taken = `resolve_valid` & `resolve_taken`.
- **Priority, highest first:**
  1. Freeze (`mem_wait`): all `*_en`=0, all flushes=0, shadow held, counters held. Resolve inputs are ignored while frozen; they are re-presented after the freeze.
  2. Taken flush: all enables=1, `ifid_flush`=`idex_flush`=1, `exmem_flush`=(`RESOLVE_STAGE`==2). `flush_cnt`+1.
  3. Data stall: `pc_en`=`ifid_en`=0, `idex_flush`=1, other enables=1. `stall_cnt`+1.
  4. Normal: all enables=1, flushes=0.
- **Shadow update, when not frozen:**
  - `sh[k]` ← `sh[k-1]` for k ≥ 2.
  - `sh[1]` ← {`id_valid`&`id_wen`&(`id_wsel`≠0), `id_wsel`, `id_is_load`} in the normal case; invalid on a data stall or a taken flush.
  - On a taken flush, `sh[2..RESOLVE_STAGE]` are also written invalid, because they receive squashed younger instructions.
- Counters saturate at all-ones.
- All decisions are combinational from the inputs and `sh`. Only `sh` and the counters are sequential.

## Timing
- **Reset** (`RST` sampled high at a `CLK` edge): all `sh.valid`=0, counters=0.
  - While `RST` is high: all `*_en`=0, all flushes=1, `data_stall`=0.
  - The first cycle after `RST` falls behaves as Normal.
- **Stall latency.** A hazard is detected in the same cycle the dependent instruction sits in ID. The hazard clears the cycle after the producer advances beyond the blocking stage.
- **Stall lengths from back-to-back issue:**
  - `FWD`=1, load-use, `LOAD_USE_DIST`=1: 1 cycle.
  - `FWD`=0, `NSH`=3: 3 cycles.
- **Freeze.** During a data stall the freeze dominates. Stall cycles are not counted while frozen, and the stall resumes after `mem_wait` drops.
- **Flush vs. stall in the same cycle.** The flush wins, the stall is not counted, and the ID instruction is discarded.
- **Reset mid-stall or mid-freeze.** The shadow is cleared, so no stall follows reset.

## Test plan
- **Load-use** (`FWD`=1): `lw $8` then `add $9,$8,$1`.
  - Exactly 1 cycle with `data_stall`=1, `pc_en`=`ifid_en`=0, `idex_flush`=1.
  - `stall_cnt`=1; the next cycle is Normal.
- **No forwarding** (`FWD`=0): `addi $5` then `or $6,$5,$0` → 3 consecutive stall cycles, `stall_cnt`=3. Repeating with `$0` as the destination → 0 stalls.
- **Freeze during stall:** a load-use stall with `mem_wait`=1 held 4 cycles.
  - All enables=0 and `stall_cnt` unchanged during the freeze.
  - After `mem_wait` drops: exactly 1 stall cycle.
- **Taken resolve** (`RESOLVE_STAGE`=2) while a load to `$8` is in `sh[1]` and ID uses `$8`:
  - That cycle: all three flushes=1, `flush_cnt`=1, `stall_cnt`=0.
  - Next: `sh[1..2]` invalid; a following `add` using `$8` does not stall.
- **Reset mid-stall:** `RST` is asserted during a `FWD`=0 stall.
  - While high: enables=0, flushes=1, counters read 0.
  - After release: a use of `$5` issues with no stall.
- **Counter saturation** (`CNT_W`=4): 20 load-use stalls → `stall_cnt`=15.

Source files
------------

// File: rtl/hazard_scoreboard_if.sv
// hazard_scoreboard_if: ID-stage operands, memory/resolve status and pipeline latch controls
interface hazard_scoreboard_if #(
  parameter int RW = 5,
  parameter int CNT_W = 32
);
  logic id_valid;
  logic [RW-1:0] id_rs;
  logic [RW-1:0] id_rt;
  logic id_rs_used;
  logic id_rt_used;
  logic id_wen;
  logic [RW-1:0] id_wsel;
  logic id_is_load;
  logic mem_wait;
  logic resolve_valid;
  logic resolve_taken;
  logic pc_en;
  logic ifid_en;
  logic idex_en;
  logic exmem_en;
  logic memwb_en;
  logic ifid_flush;
  logic idex_flush;
  logic exmem_flush;
  logic data_stall;
  logic [CNT_W-1:0] stall_cnt;
  logic [CNT_W-1:0] flush_cnt;
  modport master (
    output id_valid, id_rs, id_rt, id_rs_used, id_rt_used, id_wen, id_wsel, id_is_load,
    output mem_wait, resolve_valid, resolve_taken,
    input pc_en, ifid_en, idex_en, exmem_en, memwb_en,
    input ifid_flush, idex_flush, exmem_flush, data_stall, stall_cnt, flush_cnt
  );
  modport slave (
    input id_valid, id_rs, id_rt, id_rs_used, id_rt_used, id_wen, id_wsel, id_is_load,
    input mem_wait, resolve_valid, resolve_taken,
    output pc_en, ifid_en, idex_en, exmem_en, memwb_en,
    output ifid_flush, idex_flush, exmem_flush, data_stall, stall_cnt, flush_cnt
  );
endinterface

// File: rtl/hazard_scoreboard.sv
// hazard_scoreboard: shadow-pipeline RAW/load-use stall, flush and freeze control with perf counters
module hazard_scoreboard #(
  parameter int RW = 5,
  parameter int FWD = 1,
  parameter int NSH = 3,
  parameter int LOAD_USE_DIST = 1,
  parameter int RESOLVE_STAGE = 2,
  parameter int CNT_W = 32
) (
  input logic CLK,
  input logic RST,
  hazard_scoreboard_if.slave hz
);
  logic [NSH:1] sh_v;
  logic [NSH:1] sh_l;
  logic [RW-1:0] sh_w [1:NSH];
  logic [CNT_W-1:0] stall_cnt;
  logic [CNT_W-1:0] flush_cnt;
  logic taken;
  logic hazard;
  logic run;
  logic flush;
  logic stall;
  // a source conflicts with an older in-flight write; forwarding only leaves young loads blocking
  always_comb begin
    hazard = 1'b0;
    for (int k = 1; k <= NSH; k++)
      if (sh_v[k] &&
          ((hz.id_rs_used && hz.id_rs != '0 && hz.id_rs == sh_w[k]) ||
           (hz.id_rt_used && hz.id_rt != '0 && hz.id_rt == sh_w[k])) &&
          (FWD == 0 || (sh_l[k] && k <= LOAD_USE_DIST)))
        hazard = 1'b1;
  end
  assign taken = hz.resolve_valid & hz.resolve_taken;
  assign run = ~RST & ~hz.mem_wait;
  assign flush = run & taken;
  assign stall = run & ~taken & hz.id_valid & hazard;
  assign hz.data_stall = stall;
  assign hz.pc_en = run & ~stall;
  assign hz.ifid_en = run & ~stall;
  assign hz.idex_en = run;
  assign hz.exmem_en = run;
  assign hz.memwb_en = run;
  assign hz.ifid_flush = RST | flush;
  assign hz.idex_flush = RST | flush | stall;
  assign hz.exmem_flush = RST | (flush & (RESOLVE_STAGE == 2));
  assign hz.stall_cnt = stall_cnt;
  assign hz.flush_cnt = flush_cnt;
  // advance the shadow with the pipeline; squashed slots become bubbles, everything holds on memory wait
  always_ff @(posedge CLK) begin
    if (RST) begin
      sh_v <= '0;
      sh_l <= '0;
      for (int k = 1; k <= NSH; k++) sh_w[k] <= '0;
      stall_cnt <= '0;
      flush_cnt <= '0;
    end else if (!hz.mem_wait) begin
      sh_v[1] <= hz.id_valid & hz.id_wen & (hz.id_wsel != '0) & ~stall & ~taken;
      sh_w[1] <= hz.id_wsel;
      sh_l[1] <= hz.id_is_load;
      for (int k = 2; k <= NSH; k++) begin
        sh_v[k] <= sh_v[k-1] & ~(taken && k <= RESOLVE_STAGE);
        sh_w[k] <= sh_w[k-1];
        sh_l[k] <= sh_l[k-1];
      end
      if (taken && flush_cnt != '1) flush_cnt <= flush_cnt + 1'b1;
      if (stall && stall_cnt != '1) stall_cnt <= stall_cnt + 1'b1;
    end
  end
endmodule
